// File: rtl/pi_permute_stream.sv
// Streaming Keccak-style pi lane permutation over a state of SLICES 25-bit slices.
// Each slice is loaded, permuted a latched number of times (one pi per cycle), then emitted.
module pi_permute_stream #(
  parameter int SLICES = 64,
  parameter int RND_W  = 4
) (
  input  logic                                             i_clk,
  input  logic                                             i_rst,
  input  logic                                             i_start,
  input  logic [RND_W-1:0]                                 i_rounds,
  input  logic                                             i_inverse,
  input  logic                                             i_inValid,
  input  logic [24:0]                                      i_inData,
  output logic                                             o_inReady,
  output logic                                             o_outValid,
  output logic [24:0]                                      o_outData,
  input  logic                                             i_outReady,
  output logic                                             o_busy,
  output logic                                             o_done,
  output logic [((SLICES > 1) ? $clog2(SLICES) : 1)-1:0]   o_sliceIdx
);

  localparam int IDX_W = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, PERM, OUT, DONE} state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [24:0]       r_slice;
  logic [RND_W-1:0]  r_rounds;
  logic [RND_W-1:0]  r_roundCnt;
  logic              r_inverse;
  logic [IDX_W-1:0]  r_sliceIdx;
  logic [RND_W-1:0]  w_roundNext;
  logic              w_lastSlice;

  // Bit i = x + 5*y; each output lane gathers from its pi source lane.
  function automatic logic [24:0] piStep(input logic [24:0] s, input logic inv);
    logic [24:0] o;
    o = '0;
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        if (inv) o[x + 5*y] = s[y + 5*((2*x + 3*y) % 5)];
        else     o[x + 5*y] = s[((x + 3*y) % 5) + 5*x];
      end
    end
    return o;
  endfunction

  assign w_roundNext = r_roundCnt + RND_W'(1);
  assign w_lastSlice = (r_sliceIdx == LAST_IDX);

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (i_start) w_nextState = LOAD;
      LOAD: if (i_inValid) w_nextState = (r_rounds == '0) ? OUT : PERM;
      PERM: if (w_roundNext == r_rounds) w_nextState = OUT;
      OUT:  if (i_outReady) w_nextState = w_lastSlice ? DONE : LOAD;
      DONE: w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_slice    <= '0;
      r_rounds   <= '0;
      r_roundCnt <= '0;
      r_inverse  <= 1'b0;
      r_sliceIdx <= '0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_rounds   <= i_rounds;
            r_inverse  <= i_inverse;
            r_roundCnt <= '0;
            r_sliceIdx <= '0;
          end
        end
        LOAD: if (i_inValid) r_slice <= i_inData;
        PERM: begin
          r_slice    <= piStep(r_slice, r_inverse);
          r_roundCnt <= w_roundNext;
        end
        OUT: begin
          if (i_outReady && !w_lastSlice) begin
            r_sliceIdx <= r_sliceIdx + IDX_W'(1);
            r_roundCnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_inReady  = (r_state == LOAD);
  assign o_outValid = (r_state == OUT);
  assign o_outData  = r_slice;
  assign o_busy     = (r_state != IDLE);
  assign o_done     = (r_state == DONE);
  assign o_sliceIdx = r_sliceIdx;

endmodule
